// File: rtl/riscv_defines.sv
// Shared definitions for the interrupt scheduler: ID width and scheduler states.
package riscv_defines;

    // Width of an interrupt ID; also fixes the maximum number of lines.
    localparam int IRQ_ID_W = 5;
    localparam int MAX_IRQ  = 1 << IRQ_ID_W;

    // Scheduler states: waiting for a candidate, presenting one, post-ack gap.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } sched_state_t;

endpackage

// File: rtl/riscv_irq_rr_picker.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
// Works on a full 32-entry vector; lines that do not exist are fed as zero,
// so wrapping at 32 behaves exactly like wrapping at the real line count.
module riscv_irq_rr_picker
    import riscv_defines::*;
(
    input  logic [MAX_IRQ-1:0]  req,
    input  logic [IRQ_ID_W-1:0] ptr,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    logic [2*MAX_IRQ-1:0] req_dbl;
    logic [MAX_IRQ-1:0]   req_rot;
    logic [IRQ_ID_W-1:0]  first_rot;

    // Rotate right so that the pointer position becomes bit 0.
    assign req_dbl = {req, req};
    assign req_rot = MAX_IRQ'(req_dbl >> ptr);

    // Find-first-set on the rotated vector (lowest index wins).
    always_comb begin
        first_rot = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                first_rot = IRQ_ID_W'(i);
            end
        end
    end

    // Un-rotate: the 5-bit add wraps modulo 32 on its own.
    assign valid = |req;
    assign id    = first_rot + ptr;

endmodule

// File: rtl/riscv_irq_sched.sv
// Interrupt scheduler: pending capture, enable masking, round-robin selection
// and request/ack handshake towards the interrupt controller.
module riscv_irq_sched
    import riscv_defines::*;
#(
    parameter int NUM_IRQ     = 32,
    parameter int PULP_SECURE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq_lines_i,
    input  logic [NUM_IRQ-1:0]  edge_mode_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic [NUM_IRQ-1:0]  sec_lines_i,
    input  logic                sw_set_i,
    input  logic [IRQ_ID_W-1:0] sw_set_id_i,
    input  logic                sw_clr_i,
    input  logic [IRQ_ID_W-1:0] sw_clr_id_i,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
    output logic                irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    output logic                irq_sec_o,
    output logic [NUM_IRQ-1:0]  pending_o
);

    logic [NUM_IRQ-1:0]  lines_q;
    logic [NUM_IRQ-1:0]  pend_q;
    logic [NUM_IRQ-1:0]  pend_next;
    logic [NUM_IRQ-1:0]  sw_set_hit;
    logic [NUM_IRQ-1:0]  sw_clr_hit;
    logic [NUM_IRQ-1:0]  ack_hit;
    logic [NUM_IRQ-1:0]  cand;
    logic [MAX_IRQ-1:0]  cand_ext;
    logic [MAX_IRQ-1:0]  sec_ext;

    sched_state_t        state_q, state_next;
    logic [IRQ_ID_W-1:0] id_q, id_next;
    logic                sec_q, sec_next;
    logic [IRQ_ID_W-1:0] rr_ptr_q, rr_ptr_next;

    logic                pick_valid;
    logic [IRQ_ID_W-1:0] pick_id;

    // Per-line next pending value. Only existing lines get a decoder, so IDs
    // at or above NUM_IRQ fall through and are ignored.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            logic set_ev;
            logic clr_ev;

            assign sw_set_hit[gi] = sw_set_i  && (sw_set_id_i  == IRQ_ID_W'(gi));
            assign sw_clr_hit[gi] = sw_clr_i  && (sw_clr_id_i  == IRQ_ID_W'(gi));
            assign ack_hit[gi]    = irq_ack_i && (irq_ack_id_i == IRQ_ID_W'(gi));

            assign set_ev = (irq_lines_i[gi] & ~lines_q[gi]) | sw_set_hit[gi];
            assign clr_ev = sw_clr_hit[gi] | ack_hit[gi];

            // Edge lines: set beats clear so no event is lost. Level lines
            // track the line; a software set only lasts while it is applied.
            assign pend_next[gi] = edge_mode_i[gi]
                                 ? (set_ev | (pend_q[gi] & ~clr_ev))
                                 : (irq_lines_i[gi] | sw_set_hit[gi]);
        end
    endgenerate

    assign cand     = pend_q & irq_en_i;
    assign cand_ext = MAX_IRQ'(cand);
    assign sec_ext  = MAX_IRQ'(sec_lines_i);

    riscv_irq_rr_picker u_picker (
        .req   (cand_ext),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Line history and pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q <= '0;
            pend_q  <= '0;
        end else begin
            lines_q <= irq_lines_i;
            pend_q  <= pend_next;
        end
    end

    // Scheduler next state: latch a winner, wait for its ack, then one gap cycle.
    always_comb begin
        state_next  = state_q;
        id_next     = id_q;
        sec_next    = sec_q;
        rr_ptr_next = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_next = PRESENT;
                    id_next    = pick_id;
                    sec_next   = (PULP_SECURE != 0) && sec_ext[pick_id];
                end
            end
            PRESENT: begin
                if (irq_ack_i && (irq_ack_id_i == id_q)) begin
                    state_next  = GAP;
                    rr_ptr_next = (id_q == IRQ_ID_W'(NUM_IRQ - 1)) ? '0 : id_q + 1'b1;
                end else if (!cand_ext[id_q]) begin
                    // Masked or cleared before being taken: withdraw.
                    state_next = IDLE;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scheduler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            sec_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_next;
            id_q     <= id_next;
            sec_q    <= sec_next;
            rr_ptr_q <= rr_ptr_next;
        end
    end

    assign irq_o     = (state_q == PRESENT);
    assign irq_id_o  = id_q;
    assign irq_sec_o = sec_q;
    assign pending_o = pend_q;

endmodule

// File: tb/tb_riscv_irq_sched.sv
// Scoreboard bench for riscv_irq_sched: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them at the falling edge.
module tb_riscv_irq_sched;

    localparam int N = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_lines, edge_mode, irq_en, sec_lines;
    logic         sw_set, sw_clr, ack;
    logic [4:0]   sw_set_id, sw_clr_id, ack_id;

    logic         irq0, sec0, irq1, sec1;
    logic [4:0]   id0, id1;
    logic [N-1:0] pend0, pend1;

    always #5 clk = ~clk;

    riscv_irq_sched #(.NUM_IRQ(N), .PULP_SECURE(1)) u_dut_sec (
        .clk(clk), .rst_n(rst_n), .irq_lines_i(irq_lines), .edge_mode_i(edge_mode),
        .irq_en_i(irq_en), .sec_lines_i(sec_lines), .sw_set_i(sw_set), .sw_set_id_i(sw_set_id),
        .sw_clr_i(sw_clr), .sw_clr_id_i(sw_clr_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
        .irq_o(irq0), .irq_id_o(id0), .irq_sec_o(sec0), .pending_o(pend0)
    );

    riscv_irq_sched #(.NUM_IRQ(N), .PULP_SECURE(0)) u_dut_nsec (
        .clk(clk), .rst_n(rst_n), .irq_lines_i(irq_lines), .edge_mode_i(edge_mode),
        .irq_en_i(irq_en), .sec_lines_i(sec_lines), .sw_set_i(sw_set), .sw_set_id_i(sw_set_id),
        .sw_clr_i(sw_clr), .sw_clr_id_i(sw_clr_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
        .irq_o(irq1), .irq_id_o(id1), .irq_sec_o(sec1), .pending_o(pend1)
    );

    typedef struct packed {
        logic         irq;
        logic [4:0]   id;
        logic         sec;
        logic [N-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: pending bits, previous line values, the ID being
    // presented (-1 when none), a post-ack gap flag and the search start.
    bit   m_pend[N];
    bit   m_prev[N];
    int   m_cur;
    bit   m_gap;
    int   m_ptr;
    int   m_last_id;
    bit   m_last_sec;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_cur = -1;
        m_gap = 1'b0;
        m_ptr = 0;
        m_last_id = 0;
        m_last_sec = 1'b0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.irq = (m_cur >= 0);
        e.id  = 5'(m_last_id);
        e.sec = m_last_sec;
        for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
        return e;
    endfunction

    // One clock of behaviour, driven by the inputs currently applied.
    function automatic void model_step();
        bit cand[N];
        bit found;
        for (int i = 0; i < N; i++) cand[i] = m_pend[i] && irq_en[i];
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_cur >= 0) begin
            if (ack && int'(ack_id) == m_cur) begin
                m_ptr = (m_cur + 1) % N;
                m_cur = -1;
                m_gap = 1'b1;
            end else if (!cand[m_cur]) begin
                m_cur = -1;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && cand[c]) begin
                    found = 1'b1;
                    m_cur = c;
                    m_last_id = c;
                    m_last_sec = sec_lines[c];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            bit s_hit, c_hit;
            s_hit = (sw_set && int'(sw_set_id) == i);
            c_hit = (sw_clr && int'(sw_clr_id) == i) || (ack && int'(ack_id) == i);
            if (edge_mode[i]) begin
                if ((irq_lines[i] && !m_prev[i]) || s_hit) m_pend[i] = 1'b1;
                else if (c_hit) m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = irq_lines[i] || s_hit;
            end
            m_prev[i] = irq_lines[i];
        end
    endfunction

    // Advance one clock and queue the predicted post-edge outputs.
    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        exp_q.push_back(model_expect());
    endtask

    // Monitor: compare both instances against the predicted outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("irq_o",      32'(irq0),  32'(mon_e.irq));
            chk("irq_id_o",   32'(id0),   32'(mon_e.id));
            chk("irq_sec_o",  32'(sec0),  32'(mon_e.sec));
            chk("pending_o",  32'(pend0), 32'(mon_e.pend));
            chk("ns_irq_o",   32'(irq1),  32'(mon_e.irq));
            chk("ns_irq_id",  32'(id1),   32'(mon_e.id));
            chk("ns_sec_low", 32'(sec1),  32'd0);
            chk("ns_pending", 32'(pend1), 32'(mon_e.pend));
        end
    end

    task automatic clear_inputs();
        irq_lines = '0; edge_mode = '0; irq_en = '0; sec_lines = '0;
        sw_set = 1'b0; sw_set_id = '0; sw_clr = 1'b0; sw_clr_id = '0;
        ack = 1'b0; ack_id = '0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = model_expect();
        #1;
        chk("rst_irq_o",     32'(irq0),  32'd0);
        chk("rst_irq_id_o",  32'(id0),   32'd0);
        chk("rst_irq_sec_o", 32'(sec0),  32'd0);
        chk("rst_pending_o", 32'(pend0), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_present(string name);
        int t;
        t = 0;
        while (!irq0 && t < 40) begin
            tick();
            t++;
        end
        chk(name, 32'(irq0), 32'd1);
    endtask

    task automatic do_ack(int id);
        ack = 1'b1;
        ack_id = 5'(id);
        tick();
        ack = 1'b0;
    endtask

    int order[4] = '{3, 20, 3, 20};

    initial begin
        clear_inputs();
        model_reset();
        do_reset();
        tick();

        // Single edge interrupt on line 7 with latency and ack checks.
        irq_en[7] = 1'b1; edge_mode[7] = 1'b1;
        tick();
        irq_lines[7] = 1'b1;
        tick();
        irq_lines[7] = 1'b0;
        chk("edge_pend_n1", 32'(pend0[7]), 32'd1);
        chk("edge_irq_n1",  32'(irq0), 32'd0);
        tick();
        chk("edge_irq_n2",  32'(irq0), 32'd1);
        chk("edge_id",      32'(id0), 32'd7);
        do_ack(7);
        chk("ack_pend_clr", 32'(pend0[7]), 32'd0);
        chk("ack_gap_low",  32'(irq0), 32'd0);
        tick();
        chk("ack_idle_low", 32'(irq0), 32'd0);
        tick();

        // Round-robin between two held level lines.
        do_reset();
        irq_en[3] = 1'b1; irq_en[20] = 1'b1;
        irq_lines[3] = 1'b1; irq_lines[20] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int t;
            wait_present("rr_present");
            chk("rr_order", 32'(id0), 32'(order[k]));
            do_ack(m_last_id);
            t = 1;
            while (!irq0 && t < 10) begin
                tick();
                t++;
            end
            chk("ack_to_next", 32'(t), 32'd3);
        end
        irq_lines = '0;
        tick();
        tick();

        // Mask withdrawal with a second line waiting.
        do_reset();
        irq_en[5] = 1'b1; irq_en[9] = 1'b1;
        irq_lines[5] = 1'b1; irq_lines[9] = 1'b1;
        wait_present("mask_present");
        chk("mask_first_id", 32'(id0), 32'd5);
        irq_en[5] = 1'b0;
        tick();
        chk("mask_withdraw", 32'(irq0), 32'd0);
        wait_present("mask_next");
        chk("mask_next_id", 32'(id0), 32'd9);
        irq_lines = '0;
        do_ack(9);
        tick();

        // Set/clear collisions: new edge during ack, sw_set with sw_clr.
        do_reset();
        irq_en[7] = 1'b1; edge_mode[7] = 1'b1; edge_mode[11] = 1'b1;
        irq_lines[7] = 1'b1;
        tick();
        irq_lines[7] = 1'b0;
        wait_present("coll_present");
        tick();
        irq_lines[7] = 1'b1;
        do_ack(7);
        irq_lines[7] = 1'b0;
        chk("coll_pend_kept", 32'(pend0[7]), 32'd1);
        tick();
        chk("coll_idle_low", 32'(irq0), 32'd0);
        tick();
        chk("coll_represent", 32'(irq0), 32'd1);
        chk("coll_id", 32'(id0), 32'd7);
        do_ack(7);
        sw_set = 1'b1; sw_set_id = 5'd11; sw_clr = 1'b1; sw_clr_id = 5'd11;
        tick();
        sw_set = 1'b0; sw_clr = 1'b0;
        chk("sw_coll_set", 32'(pend0[11]), 32'd1);
        sw_clr = 1'b1;
        tick();
        sw_clr = 1'b0;
        chk("sw_clr", 32'(pend0[11]), 32'd0);
        sw_set = 1'b1; sw_set_id = 5'd30;
        tick();
        sw_set = 1'b0;
        chk("oor_id_ignored", 32'(pend0), 32'd0);
        tick();

        // Secure attribute on line 2.
        do_reset();
        sec_lines[2] = 1'b1; irq_en[2] = 1'b1; edge_mode[2] = 1'b1;
        irq_lines[2] = 1'b1;
        tick();
        irq_lines[2] = 1'b0;
        wait_present("sec_present");
        chk("sec_id", 32'(id0), 32'd2);
        chk("sec_bit", 32'(sec0), 32'd1);
        chk("nsec_bit", 32'(sec1), 32'd0);
        do_ack(2);
        tick();

        // Reset while presenting; the old event must not come back.
        irq_en[4] = 1'b1; edge_mode[4] = 1'b1; irq_lines[4] = 1'b1;
        sw_set = 1'b1; sw_set_id = 5'd6; edge_mode[6] = 1'b1;
        tick();
        irq_lines[4] = 1'b0; sw_set = 1'b0;
        wait_present("rst_present");
        do_reset();
        irq_en[4] = 1'b1; edge_mode[4] = 1'b1; irq_en[6] = 1'b1; edge_mode[6] = 1'b1;
        repeat (5) tick();
        chk("rst_no_replay", 32'(irq0), 32'd0);

        // Randomised traffic.
        do_reset();
        edge_mode = N'($urandom);
        irq_en = N'($urandom) | N'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                edge_mode = N'($urandom);
                sec_lines = N'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) irq_lines[i] = ~irq_lines[i];
                if ($urandom_range(63) == 0) irq_en[i] = ~irq_en[i];
            end
            sw_set = ($urandom_range(7) == 0);
            sw_set_id = 5'($urandom_range(31));
            sw_clr = ($urandom_range(7) == 0);
            sw_clr_id = 5'($urandom_range(31));
            if (m_cur >= 0 && $urandom_range(3) == 0) begin
                ack = 1'b1;
                ack_id = 5'(m_cur);
            end else begin
                ack = ($urandom_range(15) == 0);
                ack_id = 5'($urandom_range(31));
            end
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
